booth_core: RTL and testbench
=============================

// Module: booth_core
// PURPOSE
//  Radix-2 signed Booth multiply sequencer; downstream consumer of the Mreg multiplicand register.
//  Drives Mreg's load control and uses Mreg's registered output as multiplicand M.
//  Captures multiplier Q itself, iterates WIDTH add/sub+shift steps and returns a 2*WIDTH-bit signed product.
// PARAMETERS
//  WIDTH   4   operand width in bits (two's complement); product is 2*WIDTH bits
// PORTS
//  clk      in   1         single clock, rising edge
//  rst      in   1         asynchronous, active-high reset
//  start    in   1         request a multiply; sampled in IDLE/DONE only
//  q_in     in   WIDTH     multiplier, sampled in the start-accept cycle
//  m_in     in   WIDTH     multiplicand from Mreg output; must stay stable while busy
//  m_load   out  1         to Mreg ctrl; combinational = start & (state==IDLE | state==DONE)
//  busy     out  1         high in every CALC cycle
//  done     out  1         one-cycle pulse when product becomes valid
//  product  out  2*WIDTH   signed result; registered, held until next accepted start
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, A=0, Q=0, q_m1=0, cnt=0, product=0, busy=0, done=0.
//    m_load follows its equation, so it is 0 in IDLE with start=0.
//  - States: IDLE, CALC, DONE. busy = (state==CALC). done = (state==DONE).
//  - IDLE/DONE with start=1 (accept): m_load=1 that cycle, so Mreg loads and m_in is valid next cycle.
//    At the edge: A=0 (WIDTH+1 bits), Q=q_in, q_m1=0, cnt=WIDTH-1, state=CALC.
//  - IDLE/DONE with start=0: hold state; product unchanged.
//  - DONE always leaves after one cycle: to CALC if start, else to IDLE.
//  - CALC step, using M = sign-extended m_in (WIDTH+1 bits):
//    {Q[0],q_m1}=01: A+M.   10: A-M.   00/11: A unchanged.
//    Then arithmetic right shift of {A',Q,q_m1} by one; A' keeps its MSB.
//    cnt decrements each step. The step with cnt==0 is the last step;
//    it moves state to DONE and loads product = {A',Q} after the shift, low 2*WIDTH bits.
//  - Arithmetic: A is WIDTH+1 bits, so -(-2^(WIDTH-1)) does not overflow.
//    The product is exact for every signed operand pair, including (-2^(W-1))^2.
//  - Latency: start accepted in cycle 0; CALC in cycles 1..WIDTH; done=1 and product valid in cycle WIDTH+1.
//  - start while in CALC: ignored; m_load stays 0; no effect on operation.
//  - Back-to-back: start in the DONE cycle is accepted.
//    product stays at the old result until the new final step overwrites it.
//  - rst mid-CALC: aborts immediately to reset values; no done pulse.
//  - m_in change during CALC: undefined result (caller contract, not checked).
// STRUCTURE
//  - Package booth_pkg: state enum (IDLE, CALC, DONE) and the default WIDTH constant.
//  - Sub-module booth_addsub: (WIDTH+1)-bit adder/subtractor (a, b, sub -> y).
//    booth_core holds the FSM, counter and shift registers.
//  - All state in one always block sensitive to posedge clk / posedge rst.
//  - Next-state and add/sub select are combinational.
// TESTING
//  1. W=4: q_in=3, Mreg holds 2; start in cycle 0
//     -> m_load=1 in cycle 0; busy in cycles 1-4; done=1 in cycle 5; product=8'h06.
//  2. m=-8, q=-8 -> product=8'h40 (+64). m=7, q=-8 -> 8'hC8 (-56). m=-1, q=1 -> 8'hFF.
//  3. Pulse start in cycle 2 of CALC with a different q_in
//     -> ignored, m_load=0, done still in cycle 5, original product returned.
//  4. Assert rst in cycle 3 of CALC
//     -> state IDLE, product=0, busy=0, no done pulse.
//     Then a new start gives a correct result.
//  5. Back-to-back: start asserted in the DONE cycle with new operands (m=5, q=-3)
//     -> first product held through the second CALC; second done after 5 more cycles; product=8'hF1.
//  6. Exhaustive: all 256 signed pairs for W=4, compared against a behavioural signed multiply.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-2 Booth multiply sequencer.
package booth_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_if.sv
// Request/response bundle between the Booth sequencer and its caller.
// The caller side also owns the Mreg multiplicand register feeding m_in.
interface booth_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     q_in;
  logic [WIDTH-1:0]     m_in;
  logic                 m_load;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, q_in, m_in,
    input  m_load, busy, done, product
  );

  modport slave (
    input  start, q_in, m_in,
    output m_load, busy, done, product
  );

endinterface

// File: rtl/booth_addsub.sv
// Combinational W-bit adder/subtractor: y = a + b, or a - b when sub_i is set.
// Zero latency, no flow control.
module booth_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  // Two's complement subtract: invert b and inject the +1 as carry-in.
  assign y_o = a_i + (b_i ^ {W{sub_i}}) + W'(sub_i);

endmodule

// File: rtl/booth_core.sv
// Radix-2 signed Booth multiply sequencer; product valid WIDTH+1 cycles after accept.
// Starts are accepted only in IDLE/DONE; a start while busy is dropped.
module booth_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  booth_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 accept;
  logic                 sub;
  logic                 use_sum;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       a_pre;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH-1:0]     q_sh;

  assign accept  = bus.start & (state_q != CALC);
  assign m_ext   = {bus.m_in[WIDTH-1], bus.m_in};
  assign sub     = q_q[0] & ~qm1_q;
  assign use_sum = q_q[0] ^ qm1_q;

  booth_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a_i   (a_q),
    .b_i   (m_ext),
    .sub_i (sub),
    .y_o   (sum)
  );

  // Arithmetic right shift of {A, Q, q_m1}; the bit leaving Q becomes q_m1.
  assign a_pre = use_sum ? sum : a_q;
  assign a_sh  = {a_pre[WIDTH], a_pre[WIDTH:1]};
  assign q_sh  = {a_pre[0], q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = CALC;
          a_d     = '0;
          q_d     = bus.q_in;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          prod_d  = {a_sh[WIDTH-1:0], q_sh};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.m_load  = accept;
  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_core.sv
// Scoreboard bench for booth_core: stimulus pushes signed products, a monitor checks done/product/busy.
module tb_booth_core;

  localparam int W = 4;
  typedef logic [2*W-1:0] prod_t;
  typedef struct {
    prod_t prod;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] m_src = '0;
  logic [W-1:0] m_reg = '0;

  int   cyc = 0;
  int   last_accept = -100;
  prod_t held = '0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  booth_if #(.WIDTH(W)) bus ();

  booth_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mreg model: loads the caller's multiplicand whenever the core asks for it.
  always @(posedge clk) if (bus.m_load) m_reg <= m_src;
  assign bus.m_in = m_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Raise start for one cycle; the reference decides whether the core is free to take it.
  task automatic pulse_start(input logic [W-1:0] m, input logic [W-1:0] q);
    bit acc;
    int mi, qi;
    exp_t e;
    m_src     = m;
    bus.q_in  = q;
    bus.start = 1'b1;
    @(negedge clk);
    acc = (cyc >= last_accept + W + 1);
    chk("m_load", 32'(bus.m_load), 32'(acc));
    if (acc) begin
      mi = $signed(m);
      qi = $signed(q);
      e.prod = prod_t'(mi * qi);
      e.cyc  = cyc + W + 1;
      sb.push_back(e);
      last_accept = cyc;
    end
    tick();
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(bus.busy), 32'((cyc > last_accept) && (cyc <= last_accept + W)));
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", 32'(bus.product), 32'(e.prod));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          held = e.prod;
        end
      end else begin
        chk("product_held", 32'(bus.product), 32'(held));
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          chk("missed_done", 32'(bus.done), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int a;
    bus.start = 1'b0;
    bus.q_in  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mload", 32'(bus.m_load), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic multiply and signed corner operands
    pulse_start(4'd2, 4'd3);
    wait_until(last_accept + W + 2);
    pulse_start(4'h8, 4'h8);
    wait_until(last_accept + W + 2);
    pulse_start(4'h7, 4'h8);
    wait_until(last_accept + W + 2);
    pulse_start(4'hF, 4'h1);
    wait_until(last_accept + W + 2);

    // Start during CALC is ignored
    pulse_start(4'd3, 4'd5);
    a = last_accept;
    wait_until(a + 2);
    pulse_start(4'h9, 4'h6);
    chk("ignored_start", 32'(last_accept), 32'(a));
    wait_until(a + W + 2);

    // Reset mid-CALC aborts with no done pulse
    pulse_start(4'd6, 4'd7);
    wait_until(last_accept + 3);
    rst = 1'b1;
    sb.delete();
    last_accept = -100;
    held = '0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start(4'hD, 4'd4);

    // Back-to-back: start in the DONE cycle
    wait_until(last_accept + W + 1);
    pulse_start(4'd5, 4'hD);
    wait_until(last_accept + W + 1);

    // Random operands with random gaps, including starts while busy
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, W + 2)) tick();
      pulse_start(W'($urandom), W'($urandom));
    end

    // Exhaustive pairs, issued back-to-back
    for (int mi = 0; mi < (1 << W); mi++) begin
      for (int qi = 0; qi < (1 << W); qi++) begin
        wait_until(last_accept + W + 1);
        pulse_start(W'(mi), W'(qi));
      end
    end

    repeat (W + 3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
